// File: rtl/serializer_stream.sv
// serializer_stream: parallel-to-serial converter with a one-word holding buffer,
// valid/ready input handshake and gapless back-to-back streaming.
module serializer_stream #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             flush,
  output logic             dout,
  output logic             dout_valid,
  output logic             dout_last,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] hold_reg, hold_reg_n, shreg, shreg_n;
  logic hold_full, hold_full_n;
  logic [CW-1:0] bitcnt, bitcnt_n;
  logic active, at_last, load, accept;
  assign active     = state == SEND;
  assign at_last    = bitcnt == LAST;
  assign accept     = din_valid & ~hold_full;
  assign load       = hold_full & (~active | at_last);
  assign din_ready  = ~hold_full;
  assign dout       = LSB_FIRST ? shreg[0] : shreg[WIDTH-1];
  assign dout_valid = active;
  assign dout_last  = active & at_last;
  assign busy       = active | hold_full;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state     <= IDLE;
      hold_reg  <= '0;
      hold_full <= 1'b0;
      shreg     <= '0;
      bitcnt    <= '0;
    end else begin
      state     <= state_n;
      hold_reg  <= hold_reg_n;
      hold_full <= hold_full_n;
      shreg     <= shreg_n;
      bitcnt    <= bitcnt_n;
    end
  // The next word loads on the edge that ends the current last bit, so streams have no gaps.
  always_comb begin
    state_n     = state;
    hold_reg_n  = hold_reg;
    hold_full_n = hold_full;
    shreg_n     = shreg;
    bitcnt_n    = bitcnt;
    if (flush) begin
      state_n     = IDLE;
      hold_full_n = 1'b0;
      shreg_n     = '0;
      bitcnt_n    = '0;
    end else begin
      if (accept) begin
        hold_reg_n  = din;
        hold_full_n = 1'b1;
      end
      if (load) begin
        shreg_n     = hold_reg;
        bitcnt_n    = '0;
        state_n     = SEND;
        hold_full_n = 1'b0;
      end else if (active) begin
        shreg_n  = LSB_FIRST ? shreg >> 1 : shreg << 1;
        bitcnt_n = at_last ? '0 : bitcnt + 1'b1;
        state_n  = at_last ? IDLE : SEND;
      end
    end
  end
endmodule

// File: tb/tb_serializer_stream.sv
// tb_serializer_stream: randomized and directed checks of serializer_stream against a
// word-queue reference model; channels 0/1 are WIDTH=8 LSB/MSB first, channel 2 is WIDTH=2.
module tb_serializer_stream;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rn8 = 1'b0, v8 = 1'b0, fl8 = 1'b0, rn2 = 1'b0, v2 = 1'b0, fl2 = 1'b0;
  logic [7:0] din8 = '0;
  logic [1:0] din2 = '0;
  logic [2:0] o_r, o_d, o_v, o_l, o_b;
  serializer_stream #(.WIDTH(8), .LSB_FIRST(1'b1)) u8l (.clk(clk), .reset_n(rn8), .din(din8),
    .din_valid(v8), .din_ready(o_r[0]), .flush(fl8), .dout(o_d[0]), .dout_valid(o_v[0]),
    .dout_last(o_l[0]), .busy(o_b[0]));
  serializer_stream #(.WIDTH(8), .LSB_FIRST(1'b0)) u8m (.clk(clk), .reset_n(rn8), .din(din8),
    .din_valid(v8), .din_ready(o_r[1]), .flush(fl8), .dout(o_d[1]), .dout_valid(o_v[1]),
    .dout_last(o_l[1]), .busy(o_b[1]));
  serializer_stream #(.WIDTH(2), .LSB_FIRST(1'b1)) u2 (.clk(clk), .reset_n(rn2), .din(din2),
    .din_valid(v2), .din_ready(o_r[2]), .flush(fl2), .dout(o_d[2]), .dout_valid(o_v[2]),
    .dout_last(o_l[2]), .busy(o_b[2]));
  int n_cmp = 0, n_err = 0;
  int wd[3] = '{8, 8, 2};
  bit lsb[3] = '{1'b1, 1'b0, 1'b1};
  logic hv[3] = '{default: 1'b0};
  logic [63:0] hw[3] = '{default: '0};
  logic [63:0] cw[3] = '{default: '0};
  int rem[3] = '{default: 0};
  logic [7:0] cap_l, cap_m;
  int n_v, n_l, cyc = 0, first_v, last_v;
  // Reference: a held word plus the word on the line with a count of bits still to show.
  always @(posedge clk) begin : model
    logic rn, v, fl, acc;
    logic [63:0] d;
    for (int c = 0; c < 3; c++) begin
      rn = c < 2 ? rn8 : rn2;
      v  = c < 2 ? v8 : v2;
      fl = c < 2 ? fl8 : fl2;
      d  = c < 2 ? 64'(din8) : 64'(din2);
      if (rn) begin
        if (fl) begin
          hv[c] = 1'b0;
          rem[c] = 0;
        end else begin
          acc = v && !hv[c];
          if (rem[c] > 0) rem[c]--;
          if (rem[c] == 0 && hv[c]) begin
            cw[c] = hw[c];
            rem[c] = wd[c];
            hv[c] = 1'b0;
          end
          if (acc) begin
            hv[c] = 1'b1;
            hw[c] = d;
          end
        end
      end
    end
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_ch(input int c);
    logic ev;
    ev = rem[c] > 0;
    chk($sformatf("ch%0d valid", c), 64'(o_v[c]), 64'(ev));
    chk($sformatf("ch%0d last", c), 64'(o_l[c]), 64'(rem[c] == 1));
    chk($sformatf("ch%0d ready", c), 64'(o_r[c]), 64'(!hv[c]));
    chk($sformatf("ch%0d busy", c), 64'(o_b[c]), 64'(ev || hv[c]));
    if (ev)
      chk($sformatf("ch%0d dout", c), 64'(o_d[c]),
          64'(lsb[c] ? cw[c][wd[c] - rem[c]] : cw[c][rem[c] - 1]));
  endtask
  task automatic tick();
    @(negedge clk);
    cyc++;
    for (int c = 0; c < 3; c++) check_ch(c);
    if (o_v[0]) begin
      cap_l = {o_d[0], cap_l[7:1]};
      n_v++;
      if (o_l[0]) n_l++;
      if (first_v < 0) first_v = cyc;
      last_v = cyc;
    end
    if (o_v[1]) cap_m = {cap_m[6:0], o_d[1]};
  endtask
  task automatic clear_mon();
    cap_l = '0; cap_m = '0; n_v = 0; n_l = 0; first_v = -1; last_v = -1;
  endtask
  task automatic send8(input logic [7:0] w);
    int t;
    t = 0;
    din8 = w;
    v8 = 1'b1;
    while (!o_r[0] && t < 50) begin
      tick();
      t++;
    end
    if (t >= 50) chk("send8 ready timeout", 64'(t), 64'(0));
    tick();
    v8 = 1'b0;
  endtask
  initial begin
    clear_mon();
    repeat (2) tick();
    chk("reset dout", 64'(o_d), 64'(0));
    chk("reset ready", 64'(o_r), 64'(3'b111));
    chk("reset busy", 64'(o_b), 64'(0));
    rn8 = 1'b1;
    rn2 = 1'b1;
    repeat (20) tick();
    chk("idle valid", 64'(o_v), 64'(0));
    clear_mon();
    send8(8'hA5);
    repeat (12) tick();
    chk("A5 lsb bits", 64'(cap_l), 64'(8'hA5));
    chk("A5 msb bits", 64'(cap_m), 64'(8'hA5));
    chk("A5 valid count", 64'(n_v), 64'(8));
    chk("A5 last count", 64'(n_l), 64'(1));
    chk("A5 busy after", 64'(o_b), 64'(0));
    clear_mon();
    send8(8'h01);
    send8(8'hFF);
    send8(8'h80);
    repeat (30) tick();
    chk("b2b valid count", 64'(n_v), 64'(24));
    chk("b2b last count", 64'(n_l), 64'(3));
    chk("b2b span", 64'(last_v - first_v + 1), 64'(24));
    chk("b2b final lsb", 64'(cap_l), 64'(8'h80));
    chk("b2b final msb", 64'(cap_m), 64'(8'h80));
    send8(8'h3C);
    send8(8'hC3);
    for (int t = 0; t < 50 && rem[0] != 5; t++) tick();
    chk("flush reach bit3", 64'(rem[0]), 64'(5));
    fl8 = 1'b1;
    tick();
    fl8 = 1'b0;
    chk("flush valid", 64'(o_v[1:0]), 64'(0));
    chk("flush busy", 64'(o_b[1:0]), 64'(0));
    clear_mon();
    repeat (15) tick();
    chk("flush silent", 64'(n_v), 64'(0));
    send8(8'h0F);
    repeat (12) tick();
    chk("0F lsb bits", 64'(cap_l), 64'(8'h0F));
    chk("0F msb bits", 64'(cap_m), 64'(8'h0F));
    chk("0F valid count", 64'(n_v), 64'(8));
    repeat (300) begin
      v8 = 1'($urandom_range(0, 1));
      din8 = 8'($urandom);
      fl8 = $urandom_range(0, 30) == 0;
      tick();
    end
    v8 = 1'b0;
    fl8 = 1'b0;
    repeat (20) tick();
    repeat (400) begin
      v2 = 1'($urandom_range(0, 1));
      din2 = 2'($urandom);
      fl2 = $urandom_range(0, 40) == 0;
      tick();
      if (rem[2] > 0 && $urandom_range(0, 20) == 0) begin
        #1 rn2 = 1'b0;
        hv[2] = 1'b0;
        rem[2] = 0;
        #1;
        chk("w2 rst valid", 64'(o_v[2]), 64'(0));
        chk("w2 rst last", 64'(o_l[2]), 64'(0));
        chk("w2 rst dout", 64'(o_d[2]), 64'(0));
        chk("w2 rst busy", 64'(o_b[2]), 64'(0));
        chk("w2 rst ready", 64'(o_r[2]), 64'(1));
        tick();
        rn2 = 1'b1;
      end
    end
    v2 = 1'b0;
    fl2 = 1'b0;
    repeat (10) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
